// File: rtl/bit_serial_multiplier_array_pkg.sv
// Shared types and helpers for the bit-serial multiplier array.
// Optional two's-complement mode: BIT_SERIAL_MULT_SIGNED_EN.
package bit_serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit-counter width for a W-bit operand frame (counts up to 2W positions).
    function automatic int cnt_width(input int w);
        return $clog2(2 * w);
    endfunction

    // Plain-arithmetic product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y,
                                             input int w, input bit signed_en);
        logic [63:0] op_mask;
        logic [63:0] p_mask;
        logic [63:0] xe;
        logic [63:0] ye;
        op_mask = (64'd1 << w) - 64'd1;
        p_mask  = (64'd1 << (2 * w)) - 64'd1;
        xe      = {32'd0, x} & op_mask;
        ye      = {32'd0, y} & op_mask;
        if (signed_en) begin
            if (x[w-1]) xe = xe | ~op_mask;
            if (y[w-1]) ye = ye | ~op_mask;
        end
        return (xe * ye) & p_mask;
    endfunction

endpackage

// File: rtl/bit_serial_multiplier_array_if.sv
// Serial operand / serial product bus of the multiplier array.
interface bit_serial_multiplier_array_if;
    logic in_valid;
    logic in_ready;
    logic x;
    logic y;
    logic p_valid;
    logic p_bit;
    logic p_first;
    logic p_last;
    logic busy;
    logic err;

    modport master (
        output in_valid, x, y,
        input  in_ready, p_valid, p_bit, p_first, p_last, busy, err
    );

    modport slave (
        input  in_valid, x, y,
        output in_ready, p_valid, p_bit, p_first, p_last, busy, err
    );
endinterface

// File: rtl/bit_serial_multiplier_array_cell.sv
// One bit position of the serial-serial multiplier.
// The running sum is kept in a right-shifting frame: the sum bit moves down one
// cell per cycle while the carry stays in place, so the carry keeps its weight.
// Per cell and cycle at most 2 partial products + sum-in + carry (<=2) arrive,
// so a 2-bit carry never overflows.
module bsm_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_en,     // one frame step this cycle
    input  logic i_clr,    // frame abort: drop all state
    input  logic i_first,  // first step of a frame: ignore stale state
    input  logic i_load,   // this cell's operand bits arrive this cycle
    input  logic i_x,      // current multiplicand bit
    input  logic i_y,      // current multiplier bit
    input  logic i_sum,    // sum bit from the next-higher cell
    output logic o_sum
);
    logic       r_x;
    logic       r_y;
    logic       r_s;
    logic [1:0] r_c;

    logic       w_xr;
    logic       w_yr;
    logic       w_sin;
    logic [1:0] w_c;
    logic [1:0] w_pp;
    logic [2:0] w_total;

    // Partial products for this position plus sum-in and carry feedback.
    always_comb begin
        w_xr  = r_x & ~i_first;
        w_yr  = r_y & ~i_first;
        w_sin = i_sum & ~i_first;
        w_c   = i_first ? 2'd0 : r_c;
        if (i_load) begin
            w_pp = {1'b0, i_x & i_y};
        end else begin
            w_pp = {1'b0, i_x & w_yr} + {1'b0, i_y & w_xr};
        end
        w_total = {1'b0, w_pp} + {1'b0, w_c} + {2'b00, w_sin};
    end

    // Cell state: stored operand bits, sum bit and carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= 1'b0;
            r_y <= 1'b0;
            r_s <= 1'b0;
            r_c <= 2'd0;
        end else if (i_clr) begin
            r_x <= 1'b0;
            r_y <= 1'b0;
            r_s <= 1'b0;
            r_c <= 2'd0;
        end else if (i_en) begin
            r_s <= w_total[0];
            r_c <= w_total[2:1];
            if (i_load) begin
                r_x <= i_x;
                r_y <= i_y;
            end else if (i_first) begin
                r_x <= 1'b0;
                r_y <= 1'b0;
            end
        end
    end

    assign o_sum = r_s;
endmodule

// File: rtl/bit_serial_multiplier_array.sv
// Serial-serial W x W -> 2W multiplier, operands and product LSB-first.
// Frame: W accept cycles (IDLE/ACCUM) then W drain cycles feeding extension bits.
// Optional BIT_SERIAL_MULT_SIGNED_EN: drain replicates the operand MSBs, which makes
// the truncated 2W-bit product the exact two's-complement result.
module bit_serial_multiplier_array
    import bit_serial_mult_pkg::*;
#(
    parameter int W = 8
) (
    input logic                          clk,
    input logic                          reset,
    bit_serial_multiplier_array_if.slave bus
);
    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p_valid;
    logic             r_p_first;
    logic             r_p_last;
    logic             r_err;

    logic             w_first;
    logic             w_abort;
    logic             w_step;
    logic             w_cnt_last;
    logic             w_xs;
    logic             w_ys;
    logic [W-1:0]     w_load;
    logic [W:0]       w_sum;

    // Frame step qualifiers.
    always_comb begin
        w_first    = (r_state == IDLE) && bus.in_valid;
        w_abort    = (r_state == ACCUM) && !bus.in_valid;
        w_step     = w_first || ((r_state == ACCUM) && bus.in_valid) || (r_state == DRAIN);
        w_cnt_last = (r_cnt == CNT_LAST);
    end

`ifdef BIT_SERIAL_MULT_SIGNED_EN
    logic r_x_msb;
    logic r_y_msb;

    // Capture operand MSBs for sign extension during drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_msb <= 1'b0;
            r_y_msb <= 1'b0;
        end else if ((r_state == ACCUM) && bus.in_valid && w_cnt_last) begin
            r_x_msb <= bus.x;
            r_y_msb <= bus.y;
        end
    end

    assign w_xs = (r_state == DRAIN) ? r_x_msb : bus.x;
    assign w_ys = (r_state == DRAIN) ? r_y_msb : bus.y;
`else
    assign w_xs = (r_state == DRAIN) ? 1'b0 : bus.x;
    assign w_ys = (r_state == DRAIN) ? 1'b0 : bus.y;
`endif

    assign w_sum[W] = 1'b0;

    for (genvar j = 0; j < W; j++) begin : g_cell
        if (j == 0) begin : g_l0
            assign w_load[j] = w_first;
        end else begin : g_ln
            assign w_load[j] = (r_state == ACCUM) && bus.in_valid && (r_cnt == CNT_W'(j));
        end

        bsm_cell u_cell (
            .clk     (clk),
            .rst     (reset),
            .i_en    (w_step),
            .i_clr   (w_abort),
            .i_first (w_first),
            .i_load  (w_load[j]),
            .i_x     (w_xs),
            .i_y     (w_ys),
            .i_sum   (w_sum[j+1]),
            .o_sum   (w_sum[j])
        );
    end

    // Frame FSM with registered output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_p_valid <= w_step;
            r_p_first <= w_first;
            r_p_last  <= (r_state == DRAIN) && w_cnt_last;
            r_err     <= w_abort;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= ACCUM;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (!bus.in_valid) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_cnt_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready = ~reset & (r_state != DRAIN);
    assign bus.busy     = (r_state != IDLE);
    assign bus.p_valid  = r_p_valid;
    assign bus.p_bit    = w_sum[0];
    assign bus.p_first  = r_p_first;
    assign bus.p_last   = r_p_last;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_bit_serial_multiplier_array.sv
// Bench for bit_serial_multiplier_array: directed frames, back-to-back, abort,
// mid-frame reset and randomized frames checked against an arithmetic model.
module tb_bit_serial_multiplier_array;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bit_serial_multiplier_array_if bus ();

    bit_serial_multiplier_array #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec    = 0;
    int n_miscmp = 0;
    int cyc      = 0;

    logic [PW-1:0] exp_q[$];
    int            st_q[$];

    bit            mon_act   = 1'b0;
    logic [PW-1:0] cur_exp   = '0;
    logic [PW-1:0] acc       = '0;
    logic [PW-1:0] last_word = '0;
    int            cur_st    = 0;
    int            k         = 0;
    int            run       = 0;
    int            max_run   = 0;
    int            n_err     = 0;
    int            n_busy    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
`ifdef BIT_SERIAL_MULT_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return PW'(sa * sb);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor / scoreboard.
    initial forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
            mon_act = 1'b0;
            run     = 0;
        end else begin
            if (bus.busy) n_busy++;
            if (bus.err) begin
                n_err++;
                mon_act = 1'b0;
            end
            if (bus.p_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (!mon_act) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_pvalid", 32'(bus.p_valid), 32'd0);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        cur_st  = st_q.pop_front();
                        k       = 0;
                        acc     = '0;
                        mon_act = 1'b1;
                    end
                end
                if (mon_act) begin
                    chk("p_bit", 32'(bus.p_bit), 32'(cur_exp[k]));
                    chk("latency", 32'(cyc), 32'(cur_st + k + 1));
                    chk("p_first", 32'(bus.p_first), 32'(k == 0));
                    chk("p_last", 32'(bus.p_last), 32'(k == PW - 1));
                    acc[k] = bus.p_bit;
                    k++;
                    if (k == PW) begin
                        last_word = acc;
                        mon_act   = 1'b0;
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    // Drive nb bits of a frame; entered and left on a falling edge, in_valid left high.
    task automatic drive_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            int waited;
            waited       = 0;
            bus.x        = a[i];
            bus.y        = b[i];
            bus.in_valid = 1'b1;
            while (!bus.in_ready && waited < 4 * W) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
            if (i == 0) begin
                exp_q.push_back(model(a, b));
                st_q.push_back(cyc);
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_bits(a, b, W);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [PW-1:0] sv_exp[3];
    logic [W-1:0]  sv_a[3];
    logic [W-1:0]  sv_b[3];

    initial begin
        bus.in_valid = 1'b0;
        bus.x        = 1'b0;
        bus.y        = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_p_valid", 32'(bus.p_valid), 32'd0);
        chk("rst_p_bit",   32'(bus.p_bit),   32'd0);
        chk("rst_p_first", 32'(bus.p_first), 32'd0);
        chk("rst_p_last",  32'(bus.p_last),  32'd0);
        chk("rst_err",     32'(bus.err),     32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // 13 * 11 with busy window
        n_busy = 0;
        drive_frame(8'd13, 8'd11);
        idle(W + 3);
        chk("prod_13x11", 32'(last_word), 32'h008F);
        chk("busy_cycles", 32'(n_busy), 32'(PW - 1));

        drive_frame(8'd255, 8'd255);
        idle(W + 3);
        chk("prod_255x255", 32'(last_word), 32'hFE01);

        sv_a[0] = 8'h80; sv_b[0] = 8'h80;
        sv_a[1] = 8'hFF; sv_b[1] = 8'h01;
        sv_a[2] = 8'hFD; sv_b[2] = 8'h05;
`ifdef BIT_SERIAL_MULT_SIGNED_EN
        sv_exp[0] = 16'h4000; sv_exp[1] = 16'hFFFF; sv_exp[2] = 16'hFFF1;
`else
        sv_exp[0] = 16'h4000; sv_exp[1] = 16'h00FF; sv_exp[2] = 16'h04F1;
`endif
        for (int i = 0; i < 3; i++) begin
            drive_frame(sv_a[i], sv_b[i]);
            idle(W + 3);
            chk("prod_sign_vec", 32'(last_word), 32'(sv_exp[i]));
        end

        // back-to-back frames
        max_run = 0;
        drive_frame(8'd7, 8'd9);
        drive_frame(8'd0, 8'd200);
        drive_frame(8'd255, 8'd1);
        idle(W + 3);
        chk("b2b_pvalid_run", 32'(max_run), 32'd48);
        chk("prod_b2b_last", 32'(last_word), 32'd255);

        // abort after 4 accepted bits
        n_err = 0;
        drive_bits(8'hA5, 8'h3C, 4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_err", 32'(bus.err), 32'd1);
        chk("abort_pvalid", 32'(bus.p_valid), 32'd0);
        @(negedge clk);
        chk("abort_err_pulse", 32'(bus.err), 32'd0);
        chk("abort_pvalid2", 32'(bus.p_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_err_count", 32'(n_err), 32'd1);
        drive_frame(8'd6, 8'd7);
        idle(W + 3);
        chk("prod_after_abort", 32'(last_word), 32'd42);

        // reset in drain cycle 3
        drive_frame(8'h5A, 8'hC3);
        repeat (3) @(negedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("mrst_p_valid",  32'(bus.p_valid),  32'd0);
        chk("mrst_p_bit",    32'(bus.p_bit),    32'd0);
        chk("mrst_p_last",   32'(bus.p_last),   32'd0);
        chk("mrst_busy",     32'(bus.busy),     32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_err",      32'(bus.err),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive_frame(8'd100, 8'd3);
        idle(W + 3);
        chk("prod_after_reset", 32'(last_word), 32'd300);
        chk("no_err_on_reset", 32'(n_err), 32'd1);

        // randomized frames with random gaps
        for (int n = 0; n < 24; n++) begin
            int gap;
            drive_frame(W'($urandom), W'($urandom));
            gap = $urandom_range(0, W + 3);
            if (gap > 0) idle(gap);
        end
        idle(PW + 4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("monitor_idle", 32'(mon_act), 32'd0);
        chk("err_total", 32'(n_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
